// File: rtl/mdr_mem_ctrl.sv
// Memory data register with a req/ack transaction controller.
// Handles byte/half/word lane steering, extension and wait timeout.
module mdr_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int OFF_W      = $clog2(DATA_WIDTH/8)
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   bus_in,
  input  logic                    mdr_in,
  input  logic                    mdr_out,
  output logic [DATA_WIDTH-1:0]   bus_out,
  output logic                    bus_out_en,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [1:0]              size,
  input  logic                    sign_ext,
  input  logic [OFF_W-1:0]        byte_off,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int NB = DATA_WIDTH/8;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mdr_q, mdr_n;
  logic [7:0]            cnt, cnt_n;
  logic [1:0]            size_q, size_n;
  logic                  sext_q, sext_n;
  logic [OFF_W-1:0]      off_q, off_n;
  logic                  done_q, done_n;
  logic                  error_q, error_n;

  logic                  start_ok;
  logic [NB-1:0]         be_base;
  logic [NB-1:0]         lane_be;
  logic [DATA_WIDTH-1:0] dmask;
  logic [OFF_W+2:0]      shamt;
  logic [DATA_WIDTH-1:0] rsh;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  sbit;

  always_comb begin
    start_ok = 1'b0;
    unique case (1'b1)
      (size == 2'b00): start_ok = 1'b1;
      (size == 2'b01): start_ok = ~byte_off[0];
      (size == 2'b10): start_ok = (byte_off == '0);
      default:         start_ok = 1'b0;
    endcase
  end

  // Lane geometry follows the latched access, so it is stable while busy.
  always_comb begin
    be_base = '1;
    unique case (1'b1)
      (size_q == 2'b00): be_base = NB'(1);
      (size_q == 2'b01): be_base = NB'(3);
      default:           be_base = '1;
    endcase
  end

  always_comb begin
    dmask = '0;
    for (int b = 0; b < NB; b++) begin
      dmask[8*b +: 8] = {8{be_base[b]}};
    end
  end

  assign shamt   = {off_q, 3'b000};
  assign lane_be = be_base << off_q;
  assign rsh     = mem_rdata >> shamt;

  always_comb begin
    sbit = 1'b0;
    unique case (1'b1)
      (size_q == 2'b00): sbit = rsh[7];
      (size_q == 2'b01): sbit = rsh[15];
      default:           sbit = rsh[DATA_WIDTH-1];
    endcase
  end

  always_comb begin
    rd_val = rsh & dmask;
    if (sext_q && sbit) begin
      rd_val = rd_val | ~dmask;
    end
  end

  always_comb begin
    state_n = state;
    mdr_n   = mdr_q;
    cnt_n   = cnt;
    size_n  = size_q;
    sext_n  = sext_q;
    off_n   = off_q;
    done_n  = 1'b0;
    error_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (mdr_in) begin
          mdr_n = bus_in;
        end
        if (mem_read && mem_write) begin
          error_n = 1'b1;
        end else if (mem_read || mem_write) begin
          if (!start_ok) begin
            error_n = 1'b1;
          end else begin
            state_n = mem_read ? RD : WR;
            size_n  = size;
            sext_n  = sign_ext;
            off_n   = byte_off;
            cnt_n   = '0;
          end
        end
      end
      RD, WR: begin
        // A late ack still wins over the timeout on the same edge.
        if (mem_ack) begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (state == RD) begin
            mdr_n = rd_val;
          end
        end else if (cnt == 8'(TIMEOUT)) begin
          state_n = IDLE;
          error_n = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state   <= IDLE;
      mdr_q   <= '0;
      cnt     <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      off_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_n;
      mdr_q   <= mdr_n;
      cnt     <= cnt_n;
      size_q  <= size_n;
      sext_q  <= sext_n;
      off_q   <= off_n;
      done_q  <= done_n;
      error_q <= error_n;
    end
  end

  assign bus_out    = mdr_q;
  assign bus_out_en = mdr_out;
  assign busy       = (state != IDLE);
  assign mem_req    = (state != IDLE);
  assign mem_we     = (state == WR);
  assign mem_be     = (state == WR) ? lane_be : '0;
  assign mem_wdata  = (mdr_q & dmask) << shamt;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Directed plus random bench for mdr_mem_ctrl.
// Expected values come from an arithmetic model of the access rules.
module tb_mdr_mem_ctrl;

  localparam int TO = 15;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] bus_in;
  logic        mdr_in;
  logic        mdr_out;
  logic [31:0] bus_out;
  logic        bus_out_en;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        sign_ext;
  logic [1:0]  byte_off;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl;

  mdr_mem_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clock(clock), .clear(clear),
    .bus_in(bus_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .bus_out(bus_out), .bus_out_en(bus_out_en),
    .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .sign_ext(sign_ext), .byte_off(byte_off),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] rd,
      input logic [1:0] s, input int off, input bit sx);
    longint unsigned v;
    longint unsigned m;
    m = 64'd1 << (8 * nbytes(s));
    v = ({32'd0, rd} >> (8 * off)) % m;
    if (sx && v >= m / 2) v = v + (64'd1 << 32) - m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d,
      input logic [1:0] s, input int off);
    longint unsigned v;
    v = ({32'd0, d} % (64'd1 << (8 * nbytes(s)))) << (8 * off);
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] s, input int off);
    int v;
    v = ((1 << nbytes(s)) - 1) << off;
    return v[3:0];
  endfunction

  task automatic txn(input bit rd, input bit wr, input logic [1:0] sz,
                     input logic [1:0] off, input bit sx,
                     input logic [31:0] rdat, input int waits,
                     input bit ld, input logic [31:0] ldv);
    bit legal;
    bit ok;
    int bcnt;
    int last;
    logic [31:0] ew;
    logic [3:0]  eb;
    legal = (rd != wr) && (sz != 2'd3) && ((int'(off) % nbytes(sz)) == 0);
    mem_read = rd; mem_write = wr; size = sz; byte_off = off;
    sign_ext = sx; mdr_in = ld; bus_in = ldv;
    @(posedge clock); #1;
    mem_read = 0; mem_write = 0; mdr_in = 0;
    if (ld) mdl = ldv;
    if (!legal) begin
      @(negedge clock);
      chk("rej_error", error, 1);
      chk("rej_done", done, 0);
      chk("rej_req", mem_req, 0);
      @(negedge clock);
      chk("rej_pulse", error, 0);
      chk("rej_req2", mem_req, 0);
      chk("rej_mdr", bus_out, mdl);
      return;
    end
    ew   = ref_wdata(mdl, sz, off);
    eb   = wr ? ref_be(sz, off) : 4'd0;
    ok   = (waits <= TO);
    last = ok ? waits : TO;
    bcnt = 0;
    for (int i = 0; i <= last; i++) begin
      mem_ack   = ok && (i == waits);
      mem_rdata = (i == waits) ? rdat : $urandom;
      if (i > 0) begin
        mdr_in = 1'($urandom_range(0, 1));
        bus_in = $urandom;
      end
      @(negedge clock);
      if (busy === 1'b1 && mem_req === 1'b1) bcnt++;
      if (i == 0) begin
        chk("we", mem_we, wr);
        chk("be", mem_be, eb);
        if (wr) chk("wdata", mem_wdata, ew);
      end
      @(posedge clock); #1;
    end
    mem_ack = 0; mdr_in = 0;
    if (ok && rd) mdl = ref_read(rdat, sz, int'(off), sx);
    @(negedge clock);
    chk("busy_cycles", bcnt, last + 1);
    chk("idle_after", busy, 0);
    chk("done", done, ok);
    chk("error", error, !ok);
    chk("mdr", bus_out, mdl);
    @(negedge clock);
    chk("pulse_end", {done, error}, 0);
  endtask

  initial begin
    clear = 1; bus_in = 0; mdr_in = 0; mdr_out = 0;
    mem_read = 0; mem_write = 0; size = 0; sign_ext = 0; byte_off = 0;
    mem_rdata = 0; mem_ack = 0;
    mdl = 0;
    #12;
    chk("rst_bus", bus_out, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_flags", {done, error, mem_we}, 0);
    @(negedge clock); clear = 0;

    @(posedge clock); #1;
    bus_in = 32'hA5A5A5A5; mdr_in = 1; mdr_out = 1;
    @(posedge clock); #1;
    mdr_in = 0; bus_in = 0;
    mdl = 32'hA5A5A5A5;
    @(negedge clock);
    chk("load_bus", bus_out, 32'hA5A5A5A5);
    chk("load_en", bus_out_en, 1);
    mdr_out = 0; #1;
    chk("load_en_off", bus_out_en, 0);
    mdr_out = 1;

    txn(1, 0, 2'b10, 2'd0, 0, 32'h5A5A5A5A, 3, 0, 0);
    chk("word_read", bus_out, 32'h5A5A5A5A);
    txn(1, 0, 2'b00, 2'd2, 1, 32'h12F45678, 0, 0, 0);
    chk("byte_sext", bus_out, 32'hFFFFFFF4);
    txn(1, 0, 2'b00, 2'd2, 0, 32'h12F45678, 1, 0, 0);
    chk("byte_zext", bus_out, 32'h000000F4);
    txn(0, 1, 2'b00, 2'd3, 0, 0, 2, 1, 32'h000000AB);
    txn(0, 1, 2'b01, 2'd1, 0, 0, 0, 0, 0);
    txn(1, 0, 2'b10, 2'd0, 0, 32'hDEADBEEF, 20, 0, 0);
    chk("timeout_mdr", bus_out, 32'h000000AB);
    txn(1, 0, 2'b10, 2'd0, 0, 32'h13572468, TO, 0, 0);
    txn(1, 1, 2'b10, 2'd0, 0, 0, 0, 0, 0);
    txn(1, 0, 2'b11, 2'd0, 0, 0, 0, 0, 0);
    txn(0, 1, 2'b10, 2'd2, 0, 0, 0, 0, 0);

    for (int t = 0; t < 60; t++) begin
      bit r;
      bit w;
      int sel;
      sel = $urandom_range(0, 9);
      r = (sel < 5) || (sel == 9);
      w = (sel >= 5);
      txn(r, w, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom,
          (sel == 8) ? 17 : $urandom_range(0, 4),
          1'($urandom_range(0, 1)), $urandom);
    end

    mem_read = 1; size = 2'b10; byte_off = 0;
    @(posedge clock); #1;
    mem_read = 0;
    @(posedge clock); #3;
    chk("mid_busy", busy, 1);
    clear = 1; #1;
    chk("clr_req", mem_req, 0);
    chk("clr_busy", busy, 0);
    chk("clr_bus", bus_out, 0);
    @(negedge clock); clear = 0;
    @(negedge clock);
    chk("clr_stay", mem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
